// File: rtl/psk_symbol_scheduler_pkg.sv
// psk_pkg: shared types and constants for the PSK symbol scheduler.
//   - psk_state_e : frame FSM state encoding
//   - PH_*        : 16-bit phase constants (0/90/180/270 degrees)
//   - MODE_*      : per-frame modulation select
//   - qpsk_phase  : Gray-coded dibit to phase lookup
package psk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        GUARD    = 2'd3
    } psk_state_e;

    localparam logic [15:0] PH_0   = 16'h0000;
    localparam logic [15:0] PH_90  = 16'h4000;
    localparam logic [15:0] PH_180 = 16'h8000;
    localparam logic [15:0] PH_270 = 16'hC000;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

    // Gray order: adjacent constellation points differ in one bit.
    function automatic logic [15:0] qpsk_phase(input logic [1:0] dibit);
        case (dibit)
            2'b00:   return PH_0;
            2'b01:   return PH_90;
            2'b11:   return PH_180;
            default: return PH_270;
        endcase
    endfunction

endpackage

// File: rtl/psk_symbol_scheduler_if.sv
// psk_symbol_scheduler_if: byte stream into the scheduler.
//   tx_data  : byte to send, MSB first
//   tx_valid : tx_data/tx_last valid
//   tx_last  : byte is the final one of the frame
//   tx_ready : scheduler takes the byte this cycle
// master = byte source, slave = scheduler.
interface psk_symbol_scheduler_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, input  tx_last, output tx_ready);

endinterface

// File: rtl/psk_symbol_scheduler_mapper.sv
// psk_symbol_mapper: combinational symbol to phase-offset mapping.
//   sym_bits : next symbol bits, MSB-aligned (BPSK uses sym_bits[1] only)
//   mode     : MODE_BPSK / MODE_QPSK
//   phase    : phase offset, scaled to PHASE_WIDTH
module psk_symbol_mapper
    import psk_pkg::*;
#(
    parameter int PHASE_WIDTH = 16
) (
    input  logic [1:0]             sym_bits,
    input  logic                   mode,
    output logic [PHASE_WIDTH-1:0] phase
);

    logic [15:0] ph16;

    always_comb begin
        ph16 = PH_0;
        if (mode == MODE_QPSK)
            ph16 = qpsk_phase(sym_bits);
        else
            ph16 = sym_bits[1] ? PH_180 : PH_0;
    end

    // 16-bit constants sit in the top bits of a wider phase word.
    assign phase = PHASE_WIDTH'(ph16) << (PHASE_WIDTH - 16);

endmodule

// File: rtl/psk_symbol_scheduler.sv
// psk_symbol_scheduler: frame controller for the PSK NCO datapath.
// Sends preamble, then data symbols (BPSK or Gray QPSK), then a guard interval.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   tx               : byte stream (slave side)
//   qpsk_mode        : 0=BPSK, 1=QPSK, sampled on the frame-start accept
//   phi_inc          : NCO frequency word (constant BASE_PHASE)
//   phase_offset     : per-symbol phase offset
//   nco_en, busy     : frame in progress
//   sym_strobe       : last cycle of each symbol
//   err_underrun     : source failed to supply the next byte in time
module psk_symbol_scheduler
    import psk_pkg::*;
#(
    parameter int PHASE_WIDTH   = 16,
    parameter int BASE_PHASE    = 655,
    parameter int SYM_CYCLES    = 1000,
    parameter int PREAMBLE_SYMS = 8,
    parameter int GUARD_SYMS    = 2
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    psk_symbol_scheduler_if.slave  tx,
    input  logic                   qpsk_mode,
    output logic [PHASE_WIDTH-1:0] phi_inc,
    output logic [PHASE_WIDTH-1:0] phase_offset,
    output logic                   nco_en,
    output logic                   sym_strobe,
    output logic                   busy,
    output logic                   err_underrun
);

    localparam int SCW = $clog2(SYM_CYCLES);
    localparam int PCW = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
    localparam int GCW = (GUARD_SYMS > 1) ? $clog2(GUARD_SYMS) : 1;

    localparam logic [SCW-1:0] SYM_LAST = SCW'(SYM_CYCLES - 1);
    localparam logic [PCW-1:0] PRE_LAST = PCW'(PREAMBLE_SYMS - 1);
    localparam logic [GCW-1:0] GRD_LAST = GCW'(GUARD_SYMS - 1);

    localparam logic [PHASE_WIDTH-1:0] PH_180_S = PHASE_WIDTH'(PH_180) << (PHASE_WIDTH - 16);

    psk_state_e             state;
    logic [SCW-1:0]         sym_cnt;
    logic [PCW-1:0]         pre_cnt;
    logic [GCW-1:0]         grd_cnt;
    logic [2:0]             sym_idx;
    logic [7:0]             shreg;
    logic [7:0]             hold;
    logic                   hold_full;
    logic                   last_acc;
    logic                   mode_q;
    logic [PHASE_WIDTH-1:0] phase_q;

    logic                   beat;
    logic                   byte_end;
    logic [1:0]             map_bits;
    logic [PHASE_WIDTH-1:0] map_phase;

    assign phi_inc      = PHASE_WIDTH'(BASE_PHASE);
    assign phase_offset = phase_q;
    assign nco_en       = (state != IDLE);
    assign busy         = (state != IDLE);
    assign sym_strobe   = (state != IDLE) && (sym_cnt == SYM_LAST);

    // Once tx_last is in, the frame is closed to further bytes until IDLE.
    assign tx.tx_ready = !sys_rst &&
                         ((state == IDLE) ||
                          ((state == PREAMBLE || state == DATA) && !hold_full && !last_acc));

    assign beat     = tx.tx_valid && tx.tx_ready;
    assign byte_end = (state == DATA) && sym_strobe &&
                      (sym_idx == ((mode_q == MODE_QPSK) ? 3'd3 : 3'd7));

    // A byte arriving on the boundary strobe itself refills the shifter, so no underrun.
    assign err_underrun = byte_end && !hold_full && !beat && !last_acc;

    // Bits of the symbol that starts next cycle.
    always_comb begin
        map_bits = (mode_q == MODE_QPSK) ? shreg[5:4] : shreg[6:5];
        if (state == PREAMBLE)
            map_bits = shreg[7:6];
        else if (byte_end)
            map_bits = hold_full ? hold[7:6] : tx.tx_data[7:6];
    end

    psk_symbol_mapper #(.PHASE_WIDTH(PHASE_WIDTH)) u_mapper (
        .sym_bits (map_bits),
        .mode     (mode_q),
        .phase    (map_phase)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            sym_cnt   <= '0;
            pre_cnt   <= '0;
            grd_cnt   <= '0;
            sym_idx   <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            last_acc  <= 1'b0;
            mode_q    <= MODE_BPSK;
            phase_q   <= '0;
        end else begin
            if (state == IDLE || sym_strobe)
                sym_cnt <= '0;
            else
                sym_cnt <= sym_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (beat) begin
                        shreg     <= tx.tx_data;
                        last_acc  <= tx.tx_last;
                        mode_q    <= qpsk_mode;
                        hold_full <= 1'b0;
                        pre_cnt   <= '0;
                        sym_idx   <= '0;
                        phase_q   <= '0;
                        state     <= PREAMBLE;
                    end
                end

                PREAMBLE: begin
                    if (beat) begin
                        hold      <= tx.tx_data;
                        hold_full <= 1'b1;
                        last_acc  <= tx.tx_last;
                    end
                    if (sym_strobe) begin
                        if (pre_cnt == PRE_LAST) begin
                            state   <= DATA;
                            sym_idx <= '0;
                            phase_q <= map_phase;
                        end else begin
                            pre_cnt <= pre_cnt + 1'b1;
                            // Even preamble symbols are 0, odd are 180 degrees.
                            phase_q <= pre_cnt[0] ? '0 : PH_180_S;
                        end
                    end
                end

                DATA: begin
                    if (byte_end) begin
                        sym_idx <= '0;
                        if (hold_full) begin
                            shreg     <= hold;
                            hold_full <= 1'b0;
                            phase_q   <= map_phase;
                        end else if (beat) begin
                            shreg    <= tx.tx_data;
                            last_acc <= tx.tx_last;
                            phase_q  <= map_phase;
                        end else begin
                            state   <= GUARD;
                            grd_cnt <= '0;
                            phase_q <= '0;
                        end
                    end else begin
                        if (beat) begin
                            hold      <= tx.tx_data;
                            hold_full <= 1'b1;
                            last_acc  <= tx.tx_last;
                        end
                        if (sym_strobe) begin
                            shreg   <= (mode_q == MODE_QPSK) ? {shreg[5:0], 2'b00}
                                                             : {shreg[6:0], 1'b0};
                            sym_idx <= sym_idx + 1'b1;
                            phase_q <= map_phase;
                        end
                    end
                end

                GUARD: begin
                    if (sym_strobe) begin
                        if (grd_cnt == GRD_LAST)
                            state <= IDLE;
                        else
                            grd_cnt <= grd_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
